pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: per-register stall/flush generation, data-memory
// wait tracking with timeout-to-halt, and saturating stall/redirect counters.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_uses_rs1,
    input  logic             d_uses_rs2,
    input  logic [4:0]       e_rd,
    input  logic             e_reg_write,
    input  logic             e_is_load,
    input  logic             e_branch_taken,
    input  logic             i_mem_ready,
    input  logic             m_mem_req,
    input  logic             m_mem_ready,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_stall,
    output logic             de_flush,
    output logic             em_stall,
    output logic             em_flush,
    output logic             mw_stall,
    output logic             mw_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirects
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        dmiss;
    logic        load_use;
    logic        branch_apply;

    assign dmiss    = m_mem_req && !m_mem_ready;
    assign load_use = e_is_load && e_reg_write && (e_rd != 5'd0) &&
                      ((d_uses_rs1 && (d_rs1 == e_rd)) ||
                       (d_uses_rs2 && (d_rs2 == e_rd)));

    // Stall/flush priority: reset, halt, data miss, branch, load-use, fetch miss.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        pc_stall     = 1'b0;
        fd_stall     = 1'b0;
        fd_flush     = 1'b0;
        de_stall     = 1'b0;
        de_flush     = 1'b0;
        em_stall     = 1'b0;
        em_flush     = 1'b0;
        mw_stall     = 1'b0;
        mw_flush     = 1'b0;
        branch_apply = 1'b0;
        if (reset) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            mw_flush = 1'b1;
        end else if (state == HALT) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
            em_stall = 1'b1;
            mw_stall = 1'b1;
        end else if (dmiss) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
            em_stall = 1'b1;
            mw_flush = 1'b1;
        end else if (e_branch_taken) begin
            fd_flush     = 1'b1;
            de_flush     = 1'b1;
            branch_apply = 1'b1;
        end else if (load_use) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
        end else if (!i_mem_ready) begin
            pc_stall = 1'b1;
            fd_flush = 1'b1;
        end
    end

    // A miss that is ready on its first cycle never sets dmiss, so it never enters DWAIT.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (dmiss) begin
                    state_nxt    = DWAIT;
                    wait_cnt_nxt = 16'd1;
                end
            end
            DWAIT: begin
                if (!dmiss) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 16'd0;
                end else if (wait_cnt == TIMEOUT_W) begin
                    state_nxt = HALT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            HALT:    state_nxt = HALT;
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state        <= RUN;
            wait_cnt     <= 16'd0;
            halted       <= 1'b0;
            stall_cycles <= '0;
            redirects    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == HALT)
                halted <= 1'b1;
            if (pc_stall && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (branch_apply && (redirects != {CNT_W{1'b1}}))
                redirects <= redirects + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl: one default-parameter instance and one
// small instance (TIMEOUT=4, CNT_W=4) sharing stimulus.
module tb_pipeline_ctrl;

    // Control vector order: pc_stall fd_stall fd_flush de_stall de_flush em_stall em_flush mw_stall mw_flush
    localparam logic [8:0] CTL_NONE    = 9'b000000000;
    localparam logic [8:0] CTL_RESET   = 9'b001010101;
    localparam logic [8:0] CTL_HALT    = 9'b110101010;
    localparam logic [8:0] CTL_DMISS   = 9'b110101001;
    localparam logic [8:0] CTL_BRANCH  = 9'b001010000;
    localparam logic [8:0] CTL_LOADUSE = 9'b110010000;
    localparam logic [8:0] CTL_FMISS   = 9'b101000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs1, d_rs2, e_rd;
    logic        d_uses_rs1, d_uses_rs2, e_reg_write, e_is_load, e_branch_taken;
    logic        i_mem_ready, m_mem_req, m_mem_ready;

    logic        pc_stall, fd_stall, fd_flush, de_stall, de_flush;
    logic        em_stall, em_flush, mw_stall, mw_flush, halted;
    logic [15:0] stall_cycles, redirects;

    logic        s_pc_stall, s_fd_stall, s_fd_flush, s_de_stall, s_de_flush;
    logic        s_em_stall, s_em_flush, s_mw_stall, s_mw_flush, s_halted;
    logic [3:0]  s_stall_cycles, s_redirects;

    logic [8:0]  ctl, s_ctl;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign ctl   = {pc_stall, fd_stall, fd_flush, de_stall, de_flush,
                    em_stall, em_flush, mw_stall, mw_flush};
    assign s_ctl = {s_pc_stall, s_fd_stall, s_fd_flush, s_de_stall, s_de_flush,
                    s_em_stall, s_em_flush, s_mw_stall, s_mw_flush};

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
        .e_rd(e_rd), .e_reg_write(e_reg_write), .e_is_load(e_is_load),
        .e_branch_taken(e_branch_taken), .i_mem_ready(i_mem_ready),
        .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
        .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
        .de_stall(de_stall), .de_flush(de_flush), .em_stall(em_stall),
        .em_flush(em_flush), .mw_stall(mw_stall), .mw_flush(mw_flush),
        .halted(halted), .stall_cycles(stall_cycles), .redirects(redirects)
    );

    pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
        .e_rd(e_rd), .e_reg_write(e_reg_write), .e_is_load(e_is_load),
        .e_branch_taken(e_branch_taken), .i_mem_ready(i_mem_ready),
        .m_mem_req(m_mem_req), .m_mem_ready(m_mem_ready),
        .pc_stall(s_pc_stall), .fd_stall(s_fd_stall), .fd_flush(s_fd_flush),
        .de_stall(s_de_stall), .de_flush(s_de_flush), .em_stall(s_em_stall),
        .em_flush(s_em_flush), .mw_stall(s_mw_stall), .mw_flush(s_mw_flush),
        .halted(s_halted), .stall_cycles(s_stall_cycles), .redirects(s_redirects)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        d_rs1 = 5'd0; d_rs2 = 5'd0; d_uses_rs1 = 1'b0; d_uses_rs2 = 1'b0;
        e_rd = 5'd0; e_reg_write = 1'b0; e_is_load = 1'b0; e_branch_taken = 1'b0;
        i_mem_ready = 1'b1; m_mem_req = 1'b0; m_mem_ready = 1'b1;
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        e_is_load = 1'b1; e_reg_write = 1'b1; e_rd = rd;
        d_rs1 = 5'd5; d_uses_rs1 = 1'b1;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        m_mem_req = 1'b1; m_mem_ready = 1'b0; e_branch_taken = 1'b1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CTL_RESET) begin
            n_bad++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RESET);
        end
        tick();
        n_cmp++;
        if ({halted, stall_cycles, redirects} !== 33'd0) begin
            n_bad++; $display("FAIL reset_regs: halted=%b stall=%0d redir=%0d expected 0/0/0",
                              halted, stall_cycles, redirects);
        end
        n_cmp++;
        if (dut.wait_cnt !== 16'd0) begin
            n_bad++; $display("FAIL reset_wait_cnt: got %0d expected 0", dut.wait_cnt);
        end
        reset = 1'b0;
        clear_inputs();
        n_cmp++;
        if (ctl !== CTL_NONE) begin
            n_bad++; $display("FAIL post_reset_idle: got %b expected %b", ctl, CTL_NONE);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        set_load_use(5'd5);
        n_cmp++;
        if (ctl !== CTL_LOADUSE) begin
            n_bad++; $display("FAIL load_use_rs1: got %b expected %b", ctl, CTL_LOADUSE);
        end
        tick();
        n_cmp++;
        if (stall_cycles !== 16'd1) begin
            n_bad++; $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
        end
        d_uses_rs1 = 1'b0; d_rs2 = 5'd5; d_uses_rs2 = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CTL_LOADUSE) begin
            n_bad++; $display("FAIL load_use_rs2: got %b expected %b", ctl, CTL_LOADUSE);
        end
        d_uses_rs2 = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== CTL_NONE) begin
            n_bad++; $display("FAIL load_use_unused_src: got %b expected %b", ctl, CTL_NONE);
        end
        set_load_use(5'd5);
        e_is_load = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== CTL_NONE) begin
            n_bad++; $display("FAIL load_use_not_load: got %b expected %b", ctl, CTL_NONE);
        end
        e_is_load = 1'b1; e_reg_write = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== CTL_NONE) begin
            n_bad++; $display("FAIL load_use_no_write: got %b expected %b", ctl, CTL_NONE);
        end
        e_reg_write = 1'b1; d_rs1 = 5'd6;
        #1;
        n_cmp++;
        if (ctl !== CTL_NONE) begin
            n_bad++; $display("FAIL load_use_other_reg: got %b expected %b", ctl, CTL_NONE);
        end
    endtask

    task automatic test_x0_guard();
        clear_inputs();
        set_load_use(5'd0);
        d_rs1 = 5'd0;
        #1;
        n_cmp++;
        if (ctl !== CTL_NONE) begin
            n_bad++; $display("FAIL x0_guard: got %b expected %b", ctl, CTL_NONE);
        end
        tick();
        n_cmp++;
        if (stall_cycles !== 16'd1) begin
            n_bad++; $display("FAIL x0_guard_count: got %0d expected 1", stall_cycles);
        end
    endtask

    task automatic test_fetch_miss();
        clear_inputs();
        i_mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== CTL_FMISS) begin
            n_bad++; $display("FAIL fetch_miss: got %b expected %b", ctl, CTL_FMISS);
        end
        set_load_use(5'd5);
        n_cmp++;
        if (ctl !== CTL_LOADUSE) begin
            n_bad++; $display("FAIL fetch_miss_vs_load_use: got %b expected %b", ctl, CTL_LOADUSE);
        end
        tick();
        n_cmp++;
        if (stall_cycles !== 16'd2) begin
            n_bad++; $display("FAIL fetch_miss_count: got %0d expected 2", stall_cycles);
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        set_load_use(5'd5);
        i_mem_ready = 1'b0; e_branch_taken = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CTL_BRANCH) begin
            n_bad++; $display("FAIL branch_override: got %b expected %b", ctl, CTL_BRANCH);
        end
        tick();
        n_cmp++;
        if ({redirects, stall_cycles} !== {16'd1, 16'd2}) begin
            n_bad++; $display("FAIL branch_counts: redir=%0d stall=%0d expected 1/2",
                              redirects, stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        apply_reset();
        set_load_use(5'd5);
        e_branch_taken = 1'b1; m_mem_req = 1'b1; m_mem_ready = 1'b0;
        #1;
        for (int i = 1; i <= 3; i++) begin
            n_cmp++;
            if (ctl !== CTL_DMISS) begin
                n_bad++; $display("FAIL mem_wait_ctl[%0d]: got %b expected %b", i, ctl, CTL_DMISS);
            end
            tick();
            n_cmp++;
            if (dut.wait_cnt !== 16'(i)) begin
                n_bad++; $display("FAIL mem_wait_cnt[%0d]: got %0d expected %0d", i, dut.wait_cnt, i);
            end
        end
        m_mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CTL_BRANCH) begin
            n_bad++; $display("FAIL mem_wait_ready_branch: got %b expected %b", ctl, CTL_BRANCH);
        end
        tick();
        n_cmp++;
        if ({stall_cycles, redirects, dut.wait_cnt} !== {16'd3, 16'd1, 16'd0}) begin
            n_bad++; $display("FAIL mem_wait_done: stall=%0d redir=%0d wait=%0d expected 3/1/0",
                              stall_cycles, redirects, dut.wait_cnt);
        end
        clear_inputs();
        m_mem_req = 1'b1; m_mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== CTL_NONE) begin
            n_bad++; $display("FAIL mem_ready_first_cycle: got %b expected %b", ctl, CTL_NONE);
        end
        tick();
        n_cmp++;
        if (dut.wait_cnt !== 16'd0) begin
            n_bad++; $display("FAIL mem_ready_no_dwait: wait_cnt got %0d expected 0", dut.wait_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_inputs();
        apply_reset();
        m_mem_req = 1'b1; m_mem_ready = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) tick();
        n_cmp++;
        if ({s_halted, s_ctl} !== {1'b0, CTL_DMISS}) begin
            n_bad++; $display("FAIL timeout_early: halted=%b ctl=%b expected 0/%b",
                              s_halted, s_ctl, CTL_DMISS);
        end
        tick();
        n_cmp++;
        if ({s_halted, s_ctl} !== {1'b1, CTL_HALT}) begin
            n_bad++; $display("FAIL timeout_halt: halted=%b ctl=%b expected 1/%b",
                              s_halted, s_ctl, CTL_HALT);
        end
        m_mem_ready = 1'b1; e_branch_taken = 1'b1;
        #1;
        n_cmp++;
        if (s_ctl !== CTL_HALT) begin
            n_bad++; $display("FAIL halt_sticky_ctl: got %b expected %b", s_ctl, CTL_HALT);
        end
        tick();
        n_cmp++;
        if ({s_halted, s_stall_cycles, s_redirects} !== {1'b1, 4'd6, 4'd0}) begin
            n_bad++; $display("FAIL halt_counts: halted=%b stall=%0d redir=%0d expected 1/6/0",
                              s_halted, s_stall_cycles, s_redirects);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (s_ctl !== CTL_RESET) begin
            n_bad++; $display("FAIL halt_reset_ctl: got %b expected %b", s_ctl, CTL_RESET);
        end
        tick();
        reset = 1'b0;
        clear_inputs();
        n_cmp++;
        if ({s_halted, s_stall_cycles, s_redirects, s_ctl} !== {1'b0, 4'd0, 4'd0, CTL_NONE}) begin
            n_bad++; $display("FAIL halt_recover: halted=%b stall=%0d redir=%0d ctl=%b expected 0/0/0/%b",
                              s_halted, s_stall_cycles, s_redirects, s_ctl, CTL_NONE);
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        apply_reset();
        i_mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if ({s_stall_cycles, stall_cycles} !== {4'd15, 16'd20}) begin
            n_bad++; $display("FAIL saturation: small=%0d wide=%0d expected 15/20",
                              s_stall_cycles, stall_cycles);
        end
        tick();
        n_cmp++;
        if (s_stall_cycles !== 4'd15) begin
            n_bad++; $display("FAIL saturation_hold: got %0d expected 15", s_stall_cycles);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_x0_guard();
        test_fetch_miss();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
